// File: rtl/wb_select_unit_if.sv
// Writeback-select bus: control-unit request, per-source data/ready, register-file write port.
// The slave side is the select unit; the master side is the control unit plus datapath sources.
interface wb_select_unit_if #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 10,
  parameter int SEL_W  = 4
);
  logic                    wb_start;
  logic [SEL_W-1:0]        wb_sel;
  logic [4:0]              wb_dest;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ready;
  logic                    wb_busy;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;
  logic                    wb_done;
  logic                    wb_err;

  modport master (
    output wb_start, wb_sel, wb_dest, src_data, src_ready,
    input  wb_busy, rf_we, rf_waddr, rf_wdata, wb_done, wb_err
  );

  modport slave (
    input  wb_start, wb_sel, wb_dest, src_data, src_ready,
    output wb_busy, rf_we, rf_waddr, rf_wdata, wb_done, wb_err
  );
endinterface

// File: rtl/wb_select_unit.sv
// Registered writeback select: picks one source, waits for its ready, issues one RF write pulse.
// Latency: write 1 cycle after start when ready; no backpressure, starts while busy are dropped.
module wb_select_unit #(
  parameter int                 DATA_W    = 32,
  parameter int                 N_SRC     = 10,
  parameter int                 SEL_W     = 4,
  parameter int                 CONST_IDX = 9,
  parameter logic [DATA_W-1:0]  CONST_VAL = 32'd227,
  parameter int                 TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  wb_select_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  state_t            state;
  logic [SEL_W-1:0]  sel_q;
  logic [4:0]        dest_q;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic [DATA_W-1:0] q_data;
  logic              q_rdy;
  logic              sel_bad;
  logic              sel_const;

  // Out-of-range selects resolve to zero data / not ready instead of indexing past the bus.
  always_comb begin
    in_data = '0;
    in_rdy  = 1'b0;
    q_data  = '0;
    q_rdy   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.wb_sel == SEL_W'(i)) begin
        in_data = bus.src_data[i*DATA_W +: DATA_W];
        in_rdy  = bus.src_ready[i];
      end
      if (sel_q == SEL_W'(i)) begin
        q_data = bus.src_data[i*DATA_W +: DATA_W];
        q_rdy  = bus.src_ready[i];
      end
    end
  end

  assign sel_bad   = {1'b0, bus.wb_sel} >= (SEL_W+1)'(N_SRC);
  assign sel_const = bus.wb_sel == SEL_W'(CONST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sel_q        <= '0;
      dest_q       <= '0;
      cnt          <= '0;
      bus.wb_busy  <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.wb_done  <= 1'b0;
      bus.wb_err   <= 1'b0;
    end else begin
      bus.rf_we   <= 1'b0;
      bus.wb_done <= 1'b0;
      bus.wb_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wb_start) begin
            sel_q  <= bus.wb_sel;
            dest_q <= bus.wb_dest;
            if (sel_bad) begin
              bus.wb_err <= 1'b1;
            end else if (sel_const || in_rdy) begin
              bus.rf_wdata <= sel_const ? CONST_VAL : in_data;
              bus.rf_waddr <= bus.wb_dest;
              bus.rf_we    <= bus.wb_dest != 5'd0;
              bus.wb_done  <= 1'b1;
              bus.wb_busy  <= 1'b1;
              state        <= WRITE;
            end else begin
              cnt         <= '0;
              bus.wb_busy <= 1'b1;
              state       <= WAIT;
            end
          end
        end
        WAIT: begin
          // Ready in the last counted cycle still takes priority over the timeout.
          if (q_rdy) begin
            bus.rf_wdata <= q_data;
            bus.rf_waddr <= dest_q;
            bus.rf_we    <= dest_q != 5'd0;
            bus.wb_done  <= 1'b1;
            state        <= WRITE;
          end else if (cnt == CNT_W'(TIMEOUT-1)) begin
            bus.wb_err  <= 1'b1;
            bus.wb_busy <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          bus.wb_busy <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          bus.wb_busy <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_select_unit.sv
// Scoreboard bench for wb_select_unit: expected write/error events queued at stimulus time,
// compared (including arrival cycle) when the DUT pulses wb_done or wb_err.
module tb_wb_select_unit;

  localparam int DATA_W  = 32;
  localparam int N_SRC   = 10;
  localparam int SEL_W   = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    bit          is_err;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t got;

  wb_select_unit_if #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W)) bus ();

  wb_select_unit #(
    .DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W),
    .CONST_IDX(9), .CONST_VAL(32'd227), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit is_err, input bit we, input logic [4:0] a,
                          input logic [31:0] d, input int c);
    exp_t e;
    e.is_err = is_err;
    e.we     = we;
    e.waddr  = a;
    e.wdata  = d;
    e.cyc    = c;
    sb.push_back(e);
  endtask

  // Called at a falling edge; the request is sampled at the next rising edge.
  task automatic do_start(input logic [SEL_W-1:0] sel, input logic [4:0] dest);
    bus.wb_start = 1'b1;
    bus.wb_sel   = sel;
    bus.wb_dest  = dest;
    @(negedge clk);
    bus.wb_start = 1'b0;
  endtask

  task automatic set_src(input int ch, input logic [31:0] d);
    bus.src_data[ch*DATA_W +: DATA_W] = d;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rf_we) chk("we_without_done", bus.wb_done, 1'b1);
      if (bus.wb_done || bus.wb_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {bus.wb_done, bus.wb_err}, 2'b00);
        end else begin
          got = sb.pop_front();
          chk("evt_kind", bus.wb_err, got.is_err);
          chk("evt_cycle", cyc, got.cyc);
          chk("evt_done", bus.wb_done, !got.is_err);
          chk("evt_we", bus.rf_we, got.we);
          if (!got.is_err) begin
            chk("evt_waddr", bus.rf_waddr, got.waddr);
            chk("evt_wdata", bus.rf_wdata, got.wdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    reset         = 1'b1;
    bus.wb_start  = 1'b0;
    bus.wb_sel    = '0;
    bus.wb_dest   = '0;
    bus.src_data  = '0;
    bus.src_ready = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  bus.wb_busy,  1'b0);
    chk("rst_we",    bus.rf_we,    1'b0);
    chk("rst_waddr", bus.rf_waddr, 5'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_done",  bus.wb_done,  1'b0);
    chk("rst_err",   bus.wb_err,   1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Ready source: write in the cycle right after the start edge.
    set_src(0, 32'h1234_5678);
    bus.src_ready = 10'b00_0000_0001;
    push_exp(0, 1, 5'd8, 32'h1234_5678, cyc + 1);
    do_start(4'd0, 5'd8);
    chk("ready_busy_in_write", bus.wb_busy, 1'b1);
    set_src(0, 32'h0BAD_0BAD);
    @(negedge clk);
    chk("after_write_we",   bus.rf_we,    1'b0);
    chk("after_write_done", bus.wb_done,  1'b0);
    chk("after_write_busy", bus.wb_busy,  1'b0);
    chk("wdata_held",       bus.rf_wdata, 32'h1234_5678);

    // Constant channel ignores ready.
    bus.src_ready = '0;
    push_exp(0, 1, 5'd29, 32'd227, cyc + 1);
    do_start(4'd9, 5'd29);
    @(negedge clk);

    // Start held through WRITE is dropped; a start in the next IDLE cycle is accepted.
    set_src(0, 32'h1111_0005);
    bus.src_ready = 10'b00_0000_0001;
    push_exp(0, 1, 5'd5, 32'h1111_0005, cyc + 1);
    bus.wb_start = 1'b1;
    bus.wb_sel   = 4'd0;
    bus.wb_dest  = 5'd5;
    @(negedge clk);
    @(negedge clk);
    push_exp(0, 1, 5'd6, 32'h1111_0005, cyc + 1);
    bus.wb_dest = 5'd6;
    @(negedge clk);
    bus.wb_start = 1'b0;
    @(negedge clk);

    // Stalled source: ready low for five cycles, extra start during WAIT ignored.
    bus.src_ready = '0;
    set_src(2, 32'hDEAD_BEEF);
    push_exp(0, 1, 5'd3, 32'hDEAD_BEEF, cyc + 6);
    do_start(4'd2, 5'd3);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.wb_busy) nb++;
      if (i == 1) begin
        bus.wb_start  = 1'b1;
        bus.wb_sel    = 4'd0;
        bus.wb_dest   = 5'd7;
        bus.src_ready = 10'b00_0000_0001;
      end else begin
        bus.wb_start = 1'b0;
      end
      if (i == 4) bus.src_ready[2] = 1'b1;
      if (i == 6) set_src(2, 32'h0000_0000);
      @(negedge clk);
    end
    chk("stall_busy_cycles", nb, 6);
    chk("stall_wdata_held", bus.rf_wdata, 32'hDEAD_BEEF);

    // Timeout: error exactly TIMEOUT cycles after WAIT entry, no write.
    bus.src_ready = '0;
    push_exp(1, 0, 5'd0, 32'd0, cyc + 1 + TIMEOUT);
    do_start(4'd3, 5'd4);
    repeat (TIMEOUT + 4) @(negedge clk);
    chk("timeout_busy", bus.wb_busy, 1'b0);
    chk("timeout_wdata_held", bus.rf_wdata, 32'hDEAD_BEEF);

    // Ready in the final counted cycle wins over timeout.
    set_src(3, 32'hC0FF_EE03);
    push_exp(0, 1, 5'd4, 32'hC0FF_EE03, cyc + 1 + TIMEOUT);
    do_start(4'd3, 5'd4);
    repeat (TIMEOUT - 1) @(negedge clk);
    bus.src_ready[3] = 1'b1;
    repeat (4) @(negedge clk);
    bus.src_ready = '0;

    // Illegal select: error next cycle, never busy.
    push_exp(1, 0, 5'd0, 32'd0, cyc + 1);
    do_start(4'hF, 5'd12);
    chk("illegal_busy", bus.wb_busy, 1'b0);
    @(negedge clk);

    // Destination r0: done without write enable, data still updated.
    set_src(1, 32'hA5A5_0001);
    bus.src_ready = 10'b00_0000_0010;
    push_exp(0, 0, 5'd0, 32'hA5A5_0001, cyc + 1);
    do_start(4'd1, 5'd0);
    @(negedge clk);
    chk("r0_wdata_updated", bus.rf_wdata, 32'hA5A5_0001);

    // Reset during WAIT aborts the request; later ready causes nothing.
    bus.src_ready = '0;
    set_src(5, 32'h5555_AAAA);
    do_start(4'd5, 5'd6);
    repeat (3) @(negedge clk);
    chk("wait_busy_before_rst", bus.wb_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy",  bus.wb_busy,  1'b0);
    chk("midrst_we",    bus.rf_we,    1'b0);
    chk("midrst_waddr", bus.rf_waddr, 5'd0);
    chk("midrst_wdata", bus.rf_wdata, 32'd0);
    chk("midrst_done",  bus.wb_done,  1'b0);
    chk("midrst_err",   bus.wb_err,   1'b0);
    reset = 1'b0;
    bus.src_ready = 10'b00_0010_0000;
    repeat (6) @(negedge clk);
    chk("postrst_busy", bus.wb_busy, 1'b0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_select_unit.md
# wb_select_unit

Parametrised, registered writeback-select unit for the multicycle datapath. It sits between the datapath result sources (ALU, load/store, HI/LO, LT, immediates, shifter, XCHG, stack constant) and the register-file write port. On a control-unit request it selects one of N_SRC sources, waits for that source's ready flag when needed, and issues exactly one register-file write pulse. Unlike a plain combinational select, it holds the written value stable, flags illegal selects and stalled sources, and never writes register 0.

## Interface
- DATA_W, 32, data width of every source and of rf_wdata
- N_SRC, 10, number of source channels (legal select values 0..N_SRC-1)
- SEL_W, 4, select width; N_SRC <= 2**SEL_W
- CONST_IDX, 9, channel index that reads CONST_VAL instead of src_data
- CONST_VAL, 32'd227, constant written when CONST_IDX is selected (stack start)
- TIMEOUT, 64, maximum cycles spent in WAIT before error; >= 2
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wb_start  in  1  request pulse from control unit; sampled only in IDLE
- wb_sel  in  SEL_W  source index, sampled with wb_start
- wb_dest  in  5  destination register, sampled with wb_start
- src_data  in  N_SRC*DATA_W  packed sources; channel i at bits [i*DATA_W +: DATA_W]
- src_ready  in  N_SRC  per-channel data-valid (e.g. mult/div HI/LO done)
- wb_busy  out  1  high whenever state != IDLE
- rf_we  out  1  register-file write enable, one-cycle pulse
- rf_waddr  out  5  write address, registered
- rf_wdata  out  DATA_W  write data, registered; holds last written value
- wb_done  out  1  one-cycle pulse: request finished (with or without write)
- wb_err  out  1  one-cycle pulse: illegal select or timeout

## Operation
- States: IDLE, WAIT, WRITE.
- IDLE, wb_start=1: latch sel_q=wb_sel, dest_q=wb_dest, then:
  - wb_sel >= N_SRC: wb_err=1 next cycle, stay IDLE; no write, no wb_done.
  - wb_sel == CONST_IDX: rf_wdata<=CONST_VAL, go WRITE; src_ready ignored.
  - src_ready[wb_sel]=1: rf_wdata<=channel data, go WRITE.
  - otherwise: clear counter, go WAIT.
- WAIT: each cycle, if src_ready[sel_q]=1, capture channel sel_q, go WRITE; else count++. When count reaches TIMEOUT-1 with ready still low: wb_err pulse next cycle, go IDLE, no write. Ready in the final count cycle wins over timeout.
- WRITE (exactly one cycle): rf_we=1 unless dest_q==0 (write suppressed, data still updated); wb_done=1; rf_waddr=dest_q; next state IDLE.
- Source data is captured once; changes after capture do not affect rf_wdata.
- wb_start while busy is ignored, with no queueing.
- wb_start in the same cycle as WRITE is ignored. A new request is accepted from the IDLE cycle that follows.

## Timing
- Reset (synchronous, wins over everything): state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, wb_done=0, wb_err=0, wb_busy=0, counter=0.
- Reset asserted mid-WAIT/WRITE: the write is aborted if not already pulsed; no wb_done or wb_err follows.
- Ready source: wb_start sampled at edge k; rf_we, wb_done and wb_busy are high in cycle k+1 only. Minimum turnaround is 2 cycles per request.
- Stalled source: rf_we is high in the cycle after the edge at which src_ready[sel_q] is sampled high.
- Timeout: wb_err is high exactly TIMEOUT cycles after WAIT is entered.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then wb_start sel=0 dest=8, ready[0]=1, data0=32'h1234_5678 -> cycle k+1: rf_we=1, rf_waddr=8, rf_wdata=32'h1234_5678, wb_done=1; cycle k+2 all pulses low, rf_wdata held.
- sel=9 dest=29, ready all 0 -> rf_we next cycle with rf_wdata=32'd227.
- sel=2 dest=3, ready[2]=0 for 5 cycles then 1 with data2=32'hDEAD_BEEF -> wb_busy high 6 cycles, single rf_we with 32'hDEAD_BEEF; second wb_start during WAIT ignored.
- sel=3, ready[3] never high, TIMEOUT=64 -> wb_err pulse 64 cycles after WAIT entry, no rf_we, no wb_done, back to IDLE; then ready at count 63 in a rerun -> write, no error.
- sel=4'hF (N_SRC=10) -> wb_err next cycle, no rf_we, wb_busy stays 0; sel=1 dest=0 -> wb_done=1, rf_we=0, rf_wdata updated.
- reset asserted while in WAIT -> next cycle all outputs 0, IDLE; ready arriving afterward produces no write.
